scoreboard_multi_controller: RTL

Parametrised next-generation score engine for 2-4 players, replacing the fixed two-player controller. Each player button is synchronised, debounced and edge-detected. Accepted presses increment, or in correction mode decrement, the player's saturating score. A win rule with a configurable target and lead margin (deuce-style) freezes the game until a new-game request. It sits between the raw ui_in buttons and the display controller, which consumes the flat score bus.

---
 rtl/scoreboard_multi_controller.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/scoreboard_multi_controller.sv
// Multi-player score engine: per-button sync/debounce/edge front end,
// lowest-index arbitration, saturating scores and a deuce-style win rule.

module scoreboard_btn_frontend #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_vld;
    logic             r_lvl;
    logic             r_prev;
    logic             r_armed;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_rise;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_rise    = r_lvl & ~r_prev;
    assign o_press   = r_press;

    // A button held through reset must be seen low once before it can score.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_vld   <= 2'b00;
            r_lvl   <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            r_prev  <= r_lvl;
            r_press <= w_rise & r_armed;
            if (r_sync2 == r_lvl) begin
                r_cnt <= '0;
            end else if (w_cnt_inc == CNT_MAX) begin
                r_lvl <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
            if (r_vld[1] && !r_sync2 && !r_lvl) begin
                r_armed <= 1'b1;
            end
        end
    end
endmodule

module scoreboard_multi_controller #(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_W      = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int WIN_SCORE    = 11,
    parameter int WIN_MARGIN   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PLAYERS-1:0]         buttons_i,
    input  logic                           dec_mode_i,
    input  logic                           new_game_i,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
    output logic                           point_o,
    output logic [1:0]                     point_idx_o,
    output logic                           game_over_o,
    output logic [1:0]                     winner_o
);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [31:0]        WIN_S     = 32'(WIN_SCORE);
    localparam logic [31:0]        WIN_M     = 32'(WIN_MARGIN);

    typedef enum logic {
        ST_PLAY,
        ST_OVER
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SCORE_W-1:0]   r_score [NUM_PLAYERS];
    logic                 r_point;
    logic [1:0]           r_point_idx;
    logic [1:0]           r_winner;

    logic [NUM_PLAYERS-1:0] w_press;
    logic                   w_evt_any;
    logic [1:0]             w_evt_idx;
    logic [SCORE_W-1:0]     w_sel;
    logic [SCORE_W-1:0]     w_score_new;
    logic                   w_win;
    logic [1:0]             w_win_idx;
    logic                   w_clear;
    logic                   w_upd;
    logic                   w_point_nxt;
    logic [1:0]             w_idx_nxt;
    logic [1:0]             w_winner_nxt;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_btn
        scoreboard_btn_frontend #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_fe (
            .i_clk  (clk_i),
            .i_rst  (rst_i),
            .i_btn  (buttons_i[g]),
            .o_press(w_press[g])
        );
        assign scores_o[g*SCORE_W +: SCORE_W] = r_score[g];
    end

    assign point_o     = r_point;
    assign point_idx_o = r_point_idx;
    assign game_over_o = (r_state == ST_OVER);
    assign winner_o    = r_winner;

    // Lowest-index press wins; the rest are dropped.
    always_comb begin
        w_evt_any = 1'b0;
        w_evt_idx = '0;
        w_sel     = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (w_press[p]) begin
                w_evt_any = 1'b1;
                w_evt_idx = 2'(p);
                w_sel     = r_score[p];
            end
        end
    end

    always_comb begin
        w_score_new = w_sel;
        if (dec_mode_i) begin
            if (w_sel != '0) begin
                w_score_new = w_sel - SCORE_W'(1);
            end
        end else if (w_sel != SCORE_MAX) begin
            w_score_new = w_sel + SCORE_W'(1);
        end
    end

    always_comb begin
        logic v_lead;
        w_win     = 1'b0;
        w_win_idx = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            v_lead = (32'(r_score[p]) >= WIN_S);
            for (int q = 0; q < NUM_PLAYERS; q++) begin
                if (q != p && 32'(r_score[p]) < 32'(r_score[q]) + WIN_M) begin
                    v_lead = 1'b0;
                end
            end
            if (v_lead) begin
                w_win     = 1'b1;
                w_win_idx = 2'(p);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_winner_nxt = r_winner;
        w_idx_nxt    = r_point_idx;
        w_point_nxt  = 1'b0;
        w_clear      = 1'b0;
        w_upd        = 1'b0;
        unique case (r_state)
            ST_PLAY: begin
                if (new_game_i) begin
                    w_clear      = 1'b1;
                    w_winner_nxt = '0;
                end else if (w_win) begin
                    w_state_nxt  = ST_OVER;
                    w_winner_nxt = w_win_idx;
                end else if (w_evt_any) begin
                    w_upd       = 1'b1;
                    w_point_nxt = 1'b1;
                    w_idx_nxt   = w_evt_idx;
                end
            end
            ST_OVER: begin
                if (new_game_i) begin
                    w_clear      = 1'b1;
                    w_state_nxt  = ST_PLAY;
                    w_winner_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_PLAY;
            r_point     <= 1'b0;
            r_point_idx <= '0;
            r_winner    <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_score[p] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_point     <= w_point_nxt;
            r_point_idx <= w_idx_nxt;
            r_winner    <= w_winner_nxt;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (w_clear) begin
                    r_score[p] <= '0;
                end else if (w_upd && w_evt_idx == 2'(p)) begin
                    r_score[p] <= w_score_new;
                end
            end
        end
    end
endmodule
